// File: rtl/syndrome_pkg.sv
// Shared types, constants and GF(2^m) helpers for the multi-mode BCH syndrome calculator.
package syndrome_pkg;

    localparam int unsigned SW      = 10;
    localparam int unsigned DW      = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned MAX_POW = 64;

    typedef enum logic [1:0] {
        BCH63_51    = 2'b00,
        BCH255_239  = 2'b01,
        BCH1023_983 = 2'b10,
        CODE_BAD    = 2'b11
    } code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_ODD  = 2'b10,
        ST_ALL  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] BEATS_63   = 8'd8;
    localparam logic [CNT_W-1:0] BEATS_255  = 8'd32;
    localparam logic [CNT_W-1:0] BEATS_1023 = 8'd128;

    localparam logic [SW:0] POLY_63   = 11'h043;
    localparam logic [SW:0] POLY_255  = 11'h11D;
    localparam logic [SW:0] POLY_1023 = 11'h409;

    function automatic logic [CNT_W-1:0] beats_per(input code_e code);
        case (code)
            BCH63_51:    return BEATS_63;
            BCH255_239:  return BEATS_255;
            BCH1023_983: return BEATS_1023;
            default:     return '0;
        endcase
    endfunction

    // Multiply by alpha: shift and reduce by the mode's primitive polynomial.
    function automatic logic [SW-1:0] gf_mul_alpha(input logic [SW-1:0] elem, input code_e mode);
        logic [SW:0] t;
        t = {elem, 1'b0};
        case (mode)
            BCH63_51:    if (t[6])  t = t ^ POLY_63;
            BCH255_239:  if (t[8])  t = t ^ POLY_255;
            BCH1023_983: if (t[10]) t = t ^ POLY_1023;
            default:     t = '0;
        endcase
        return t[SW-1:0];
    endfunction

    // elem * alpha^power; power is a constant at every call site so the loop folds away.
    function automatic logic [SW-1:0] gf_mul_const(input logic [SW-1:0] elem,
                                                   input int unsigned power,
                                                   input code_e mode);
        logic [SW-1:0] r;
        r = elem;
        for (int unsigned k = 0; k < MAX_POW; k++) begin
            if (k < power) r = gf_mul_alpha(r, mode);
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a,
                                             input logic [SW-1:0] b,
                                             input code_e mode);
        logic [SW-1:0] r;
        r = '0;
        for (int i = SW - 1; i >= 0; i--) begin
            r = gf_mul_alpha(r, mode);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] gf_square(input logic [SW-1:0] elem, input code_e mode);
        return gf_mul(elem, elem, mode);
    endfunction

endpackage

// File: rtl/syndrome_acc.sv
// One odd-syndrome accumulator S_J: per-beat Horner update over the selected field.
module syndrome_acc
    import syndrome_pkg::*;
#(
    parameter int unsigned J = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  code_e         i_mode,
    input  logic          i_clear,
    input  logic          i_acc,
    input  logic          i_last,
    input  logic [DW-1:0] i_data,
    output logic [SW-1:0] o_s
);

    logic [SW-1:0] s_q;
    logic [SW-1:0] s_nxt;
    logic [SW-1:0] scaled_full;
    logic [SW-1:0] scaled_last;
    logic [SW-1:0] contrib_full;
    logic [SW-1:0] contrib_last;

    // The last beat carries 7 code bits in i_data[7:1]; i_data[0] is pad.
    always_comb begin
        scaled_full  = gf_mul_const(s_q, 8 * J, i_mode);
        scaled_last  = gf_mul_const(s_q, 7 * J, i_mode);
        contrib_full = '0;
        contrib_last = '0;
        for (int unsigned b = 0; b < DW; b++) begin
            if (i_data[b]) contrib_full = contrib_full ^ gf_mul_const(SW'(1), b * J, i_mode);
            if (b > 0 && i_data[b]) contrib_last = contrib_last ^ gf_mul_const(SW'(1), (b - 1) * J, i_mode);
        end
        s_nxt = s_q;
        if (i_clear) begin
            s_nxt = contrib_full;
        end else if (i_acc) begin
            s_nxt = i_last ? (scaled_last ^ contrib_last) : (scaled_full ^ contrib_full);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) s_q <= '0;
        else          s_q <= s_nxt;
    end

    assign o_s = s_q;

endmodule

// File: rtl/syndrome.sv
// Streaming BCH syndrome calculator: odd syndromes by Horner accumulation, even ones by squaring.
module syndrome
    import syndrome_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    i_code,
    input  logic          i_clear_and_wen,
    input  logic          i_wen,
    input  logic [DW-1:0] i_data,
    output logic [SW-1:0] o_S1,
    output logic [SW-1:0] o_S2,
    output logic [SW-1:0] o_S3,
    output logic [SW-1:0] o_S4,
    output logic [SW-1:0] o_S5,
    output logic [SW-1:0] o_S6,
    output logic [SW-1:0] o_S7,
    output logic [SW-1:0] o_S8,
    output logic          o_odd_valid,
    output logic          o_all_valid
);

    state_e           state_q, state_nxt;
    code_e            code_q;
    code_e            mode_c;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             acc_c;
    logic             last_c;
    logic             load_even_c;
    logic [DW-1:0]    data_lo_c;
    logic [DW-1:0]    data_hi_c;
    logic [SW-1:0]    s1, s3, s5, s7;
    logic [SW-1:0]    s2_q, s4_q, s6_q, s8_q;
    logic [SW-1:0]    s2_c, s4_c;
    logic             hi_mode_c;

    // Next state, beat counting and data gating; a clear beat uses the incoming code.
    always_comb begin
        mode_c      = i_clear_and_wen ? code_e'(i_code) : code_q;
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        acc_c       = 1'b0;
        last_c      = 1'b0;
        load_even_c = 1'b0;
        data_lo_c   = (mode_c != CODE_BAD) ? i_data : '0;
        data_hi_c   = (mode_c == BCH1023_983) ? i_data : '0;
        if (i_clear_and_wen) begin
            state_nxt = (mode_c != CODE_BAD) ? ST_ACC : ST_IDLE;
            cnt_nxt   = CNT_W'(1);
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (i_wen) begin
                        acc_c   = 1'b1;
                        cnt_nxt = cnt_q + CNT_W'(1);
                        if (cnt_q == beats_per(code_q) - CNT_W'(1)) begin
                            last_c    = 1'b1;
                            state_nxt = ST_ODD;
                        end
                    end
                end
                ST_ODD: begin
                    load_even_c = 1'b1;
                    state_nxt   = ST_ALL;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            code_q      <= BCH63_51;
            cnt_q       <= '0;
            o_odd_valid <= 1'b0;
            o_all_valid <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            o_odd_valid <= (state_nxt == ST_ODD) || (state_nxt == ST_ALL);
            o_all_valid <= (state_nxt == ST_ALL);
            if (i_clear_and_wen) code_q <= code_e'(i_code);
        end
    end

    syndrome_acc #(.J(1)) u_acc1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(mode_c), .i_clear(i_clear_and_wen),
        .i_acc(acc_c), .i_last(last_c), .i_data(data_lo_c), .o_s(s1)
    );
    syndrome_acc #(.J(3)) u_acc3 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(mode_c), .i_clear(i_clear_and_wen),
        .i_acc(acc_c), .i_last(last_c), .i_data(data_lo_c), .o_s(s3)
    );
    syndrome_acc #(.J(5)) u_acc5 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(mode_c), .i_clear(i_clear_and_wen),
        .i_acc(acc_c), .i_last(last_c), .i_data(data_hi_c), .o_s(s5)
    );
    syndrome_acc #(.J(7)) u_acc7 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(mode_c), .i_clear(i_clear_and_wen),
        .i_acc(acc_c), .i_last(last_c), .i_data(data_hi_c), .o_s(s7)
    );

    // Even syndromes: S4 and S8 are formed from S1 in one stage so all land together.
    always_comb begin
        hi_mode_c = (code_q == BCH1023_983);
        s2_c      = gf_square(s1, code_q);
        s4_c      = gf_square(s2_c, code_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_q <= '0;
            s4_q <= '0;
            s6_q <= '0;
            s8_q <= '0;
        end else if (i_clear_and_wen) begin
            s2_q <= '0;
            s4_q <= '0;
            s6_q <= '0;
            s8_q <= '0;
        end else if (load_even_c) begin
            s2_q <= s2_c;
            s4_q <= s4_c;
            s6_q <= hi_mode_c ? gf_square(s3, code_q) : '0;
            s8_q <= hi_mode_c ? gf_square(s4_c, code_q) : '0;
        end
    end

    assign o_S1 = s1;
    assign o_S2 = s2_q;
    assign o_S3 = s3;
    assign o_S4 = s4_q;
    assign o_S5 = s5;
    assign o_S6 = s6_q;
    assign o_S7 = s7;
    assign o_S8 = s8_q;

endmodule

// File: tb/tb_syndrome.sv
// Self-checking bench for syndrome: random and directed words against a direct-sum BCH model.
module tb_syndrome;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [1:0] i_code;
    logic       i_clear_and_wen;
    logic       i_wen;
    logic [7:0] i_data;
    logic [9:0] o_S1, o_S2, o_S3, o_S4, o_S5, o_S6, o_S7, o_S8;
    logic       o_odd_valid;
    logic       o_all_valid;

    syndrome dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_code(i_code),
        .i_clear_and_wen(i_clear_and_wen), .i_wen(i_wen), .i_data(i_data),
        .o_S1(o_S1), .o_S2(o_S2), .o_S3(o_S3), .o_S4(o_S4),
        .o_S5(o_S5), .o_S6(o_S6), .o_S7(o_S7), .o_S8(o_S8),
        .o_odd_valid(o_odd_valid), .o_all_valid(o_all_valid)
    );

    always #5 i_clk = ~i_clk;

    int         total = 0;
    int         bad   = 0;
    bit         r [0:1022];
    logic [9:0] exp_s [1:8];
    logic [9:0] s_out [1:8];

    assign s_out[1] = o_S1;
    assign s_out[2] = o_S2;
    assign s_out[3] = o_S3;
    assign s_out[4] = o_S4;
    assign s_out[5] = o_S5;
    assign s_out[6] = o_S6;
    assign s_out[7] = o_S7;
    assign s_out[8] = o_S8;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int beats(input int mode);
        return (mode == 0) ? 8 : (mode == 1) ? 32 : 128;
    endfunction

    // S_j = XOR of alpha^(i*j) over set bits r_i, straight from the definition.
    task automatic model(input int mode);
        int m, poly, q, v;
        int alog [0:1022];
        m    = (mode == 0) ? 6 : (mode == 1) ? 8 : 10;
        poly = (mode == 0) ? 'h43 : (mode == 1) ? 'h11d : 'h409;
        q    = (1 << m) - 1;
        v    = 1;
        for (int k = 0; k < q; k++) begin
            alog[k] = v;
            v = v << 1;
            if (((v >> m) & 1) == 1) v = v ^ poly;
        end
        for (int j = 1; j <= 8; j++) begin
            v = 0;
            for (int i = 0; i < q; i++) begin
                if (r[i]) v = v ^ alog[(i * j) % q];
            end
            exp_s[j] = (j > 4 && mode != 2) ? 10'd0 : 10'(v);
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 1023; i++) r[i] = 1'b0;
    endtask

    task automatic send_word(input int mode, input bit pad, input int max_gap, input int nbeats);
        int n, k;
        logic [7:0] d;
        n = beats(mode);
        for (int b = 0; b < nbeats; b++) begin
            for (int t = 0; t < 8; t++) begin
                k = 8 * b + t;
                d[7 - t] = (k == 8 * n - 1) ? pad : r[8 * n - 2 - k];
            end
            i_clear_and_wen = (b == 0);
            i_wen           = 1'b1;
            i_data          = d;
            i_code          = (b == 0) ? 2'(mode) : 2'($urandom_range(0, 3));
            @(posedge i_clk); #1;
            i_clear_and_wen = 1'b0;
            i_wen           = 1'b0;
            if (b == 0) begin
                check("clear_odd_valid", 10'(o_odd_valid), 10'd0);
                check("clear_all_valid", 10'(o_all_valid), 10'd0);
            end
            if (b == n - 2) check("early_odd_valid", 10'(o_odd_valid), 10'd0);
            if (max_gap > 0 && b < n - 1) begin
                repeat ($urandom_range(0, max_gap)) begin
                    i_data = 8'($urandom);
                    i_code = 2'($urandom_range(0, 3));
                    @(posedge i_clk); #1;
                end
            end
        end
    endtask

    task automatic check_syn(input string tag);
        for (int j = 1; j <= 8; j++) check($sformatf("%s_S%0d", tag, j), s_out[j], exp_s[j]);
    endtask

    task automatic finish_word(input string tag);
        check({tag, "_odd_at_n"}, 10'(o_odd_valid), 10'd1);
        check({tag, "_all_at_n"}, 10'(o_all_valid), 10'd0);
        @(posedge i_clk); #1;
        check({tag, "_all_at_n1"}, 10'(o_all_valid), 10'd1);
        check_syn(tag);
    endtask

    task automatic run_word(input int mode, input bit pad, input int max_gap, input string tag);
        model(mode);
        send_word(mode, pad, max_gap, beats(mode));
        finish_word(tag);
    endtask

    task automatic rand_vec(input int mode);
        int n;
        n = 8 * beats(mode) - 1;
        clear_vec();
        repeat ($urandom_range(1, (mode == 2) ? 6 : 3)) r[$urandom_range(0, n - 1)] = 1'b1;
    endtask

    initial begin
        int seq [0:2];
        seq = '{2, 0, 1};
        i_rst_n = 1'b0; i_code = 2'b00; i_clear_and_wen = 1'b0; i_wen = 1'b0; i_data = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        for (int j = 1; j <= 8; j++) check($sformatf("reset_S%0d", j), s_out[j], 10'd0);
        check("reset_odd_valid", 10'(o_odd_valid), 10'd0);
        check("reset_all_valid", 10'(o_all_valid), 10'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int m = 0; m < 3; m++) begin
            clear_vec();
            run_word(m, 1'b0, 0, $sformatf("zero_m%0d", m));
        end

        clear_vec(); r[0] = 1'b1;
        run_word(0, 1'b0, 0, "m0_r0");

        clear_vec(); r[1] = 1'b1;
        run_word(2, 1'b0, 0, "m2_r1");

        clear_vec(); r[1] = 1'b1;
        run_word(1, 1'b1, 0, "m1_pad");
        run_word(1, 1'b1, 3, "m1_gap");

        // Beats beyond N must not disturb a finished word.
        repeat (5) begin
            i_wen = 1'b1; i_data = 8'($urandom); i_code = 2'($urandom_range(0, 3));
            @(posedge i_clk); #1;
        end
        i_wen = 1'b0;
        check("extra_odd_valid", 10'(o_odd_valid), 10'd1);
        check("extra_all_valid", 10'(o_all_valid), 10'd1);
        check_syn("extra");

        for (int v = 0; v < 10; v++) begin
            rand_vec(seq[v % 3]);
            run_word(seq[v % 3], 1'($urandom_range(0, 1)), (v % 2) * 2, $sformatf("rand%0d", v));
        end

        // Illegal code: word ignored, nothing becomes valid.
        i_clear_and_wen = 1'b1; i_wen = 1'b1; i_code = 2'b11; i_data = 8'hff;
        @(posedge i_clk); #1;
        i_clear_and_wen = 1'b0;
        repeat (10) begin
            i_data = 8'($urandom); i_code = 2'($urandom_range(0, 2));
            @(posedge i_clk); #1;
        end
        i_wen = 1'b0;
        @(posedge i_clk); #1;
        check("bad_odd_valid", 10'(o_odd_valid), 10'd0);
        check("bad_all_valid", 10'(o_all_valid), 10'd0);
        for (int j = 1; j <= 8; j++) check($sformatf("bad_S%0d", j), s_out[j], 10'd0);

        // Reset mid-word, then a full word must still be correct.
        rand_vec(2);
        send_word(2, 1'b0, 0, 50);
        i_rst_n = 1'b0;
        #2;
        for (int j = 1; j <= 8; j++) check($sformatf("midrst_S%0d", j), s_out[j], 10'd0);
        check("midrst_odd_valid", 10'(o_odd_valid), 10'd0);
        check("midrst_all_valid", 10'(o_all_valid), 10'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        run_word(2, 1'b1, 1, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
